// File: rtl/ifir_pkg.sv
// Shared definitions for the IFIR interpolator controllers: FSM state
// encoding and default rate/depth constants.
package ifir_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam int DIV_OUT_DEF = 4;
    localparam int TAPS_DEF    = 8;

endpackage

// File: rtl/ifir_strobe_div.sv
// Output-rate divider: free-running count of DIV_OUT master cycles producing a
// tick strobe and an alternating polyphase select (starts on a0 after clear).
module ifir_strobe_div #(
    parameter int DIV_OUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic rstn,
    input  logic run,
    input  logic clr,
    output logic tick,
    output logic ph
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV_OUT - 1));

    // clr takes effect on the same edge the controller falls back to IDLE, so
    // the counter is already at 0 with ph=a0 for the first cycle of IDLE.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            ph  <= 1'b1;
        end else if (clr) begin
            cnt <= '0;
            ph  <= 1'b1;
        end else if (run) begin
            if (tick) begin
                cnt <= '0;
                ph  <= ~ph;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ifir_2nd_rate_ctrl.sv
// Sequencing controller for the IFIR 2nd-stage x2 polyphase interpolator:
// strobe generation, upstream handshake, priming FSM and underflow status.
module ifir_2nd_rate_ctrl
    import ifir_pkg::*;
#(
    parameter int DIV_OUT = DIV_OUT_DEF,
    parameter int TAPS    = TAPS_DEF,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             clock_in,
    output logic             clock_div2,
    output logic             clock_up,
    output logic             out_valid,
    output logic             underflow,
    output logic [CNT_W-1:0] unf_cnt,
    output logic             busy
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] fill;
    logic       enable_q;
    logic       en_rise;
    logic       tick;
    logic       ph;
    logic       in_strobe;
    logic       consume;
    logic       run;
    logic       clr;

    assign run = (state != ST_IDLE);
    assign clr = (state_nxt == ST_IDLE);

    ifir_strobe_div #(
        .DIV_OUT (DIV_OUT),
        .CNT_W   (CNT_W)
    ) u_div (
        .clock (clock),
        .rstn  (rstn),
        .run   (run),
        .clr   (clr),
        .tick  (tick),
        .ph    (ph)
    );

    // The a1 tick is the load slot; during STOP it only closes the output
    // pair and must not pull a sample from upstream.
    assign in_strobe = tick & ~ph;
    assign consume   = in_strobe & ((state == ST_PRIME) || (state == ST_RUN));
    assign en_rise   = enable & ~enable_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_PRIME;
            ST_PRIME: begin
                if (!enable)
                    state_nxt = ST_IDLE;
                else if (consume && (fill == 8'(TAPS - 1)))
                    state_nxt = ST_RUN;
            end
            ST_RUN:   if (!enable) state_nxt = ST_STOP;
            ST_STOP: begin
                if (enable)
                    state_nxt = ST_RUN;
                else if (in_strobe)
                    state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            enable_q <= 1'b0;
            fill     <= '0;
        end else begin
            state    <= state_nxt;
            enable_q <= enable;
            if (state == ST_IDLE)
                fill <= '0;
            else if ((state == ST_PRIME) && consume)
                fill <= fill + 8'd1;
        end
    end

    // A fresh enable clears the status even if a starved load lands on the same edge.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            underflow <= 1'b0;
            unf_cnt   <= '0;
        end else if (en_rise) begin
            underflow <= 1'b0;
            unf_cnt   <= '0;
        end else if (consume && !in_valid) begin
            underflow <= 1'b1;
            if (!(&unf_cnt))
                unf_cnt <= unf_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = consume;
    assign clock_in   = consume;
    assign clock_div2 = ph;
    assign clock_up   = tick;
    assign out_valid  = tick & ((state == ST_RUN) || (state == ST_STOP));
    assign busy       = run;

endmodule

// File: tb/tb_ifir_2nd_rate_ctrl.sv
// Directed bench for ifir_2nd_rate_ctrl: a DIV_OUT=4 instance for sequencing
// and a DIV_OUT=2 / CNT_W=2 instance for fast-rate and saturation behaviour.
module tb_ifir_2nd_rate_ctrl;

    logic       clock;
    logic       rstn;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic       clock_in;
    logic       clock_div2;
    logic       clock_up;
    logic       out_valid;
    logic       underflow;
    logic [7:0] unf_cnt;
    logic       busy;

    logic       enable2;
    logic       in_valid2;
    logic       in_ready2;
    logic       clock_in2;
    logic       clock_div2_2;
    logic       clock_up2;
    logic       out_valid2;
    logic       underflow2;
    logic [1:0] unf_cnt2;
    logic       busy2;

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    ifir_2nd_rate_ctrl #(.DIV_OUT(4), .TAPS(8), .CNT_W(8)) dut (
        .clock      (clock),
        .rstn       (rstn),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clock_in   (clock_in),
        .clock_div2 (clock_div2),
        .clock_up   (clock_up),
        .out_valid  (out_valid),
        .underflow  (underflow),
        .unf_cnt    (unf_cnt),
        .busy       (busy)
    );

    ifir_2nd_rate_ctrl #(.DIV_OUT(2), .TAPS(8), .CNT_W(2)) dut2 (
        .clock      (clock),
        .rstn       (rstn),
        .enable     (enable2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .clock_in   (clock_in2),
        .clock_div2 (clock_div2_2),
        .clock_up   (clock_up2),
        .out_valid  (out_valid2),
        .underflow  (underflow2),
        .unf_cnt    (unf_cnt2),
        .busy       (busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic en, input logic iv);
        enable   = en;
        in_valid = iv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Cycle cyc counts edges since IDLE->PRIME: ticks on multiples of 4, odd
    // ticks are a0, even ticks are a1 and carry the load strobe.
    task automatic runTo(input int target, input int valid_from);
        logic tick_exp;
        logic ph_exp;
        while (cyc < target) begin
            step();
            cyc++;
            tick_exp = (cyc % 4 == 0);
            ph_exp   = (((cyc - 1) / 4) % 2 == 0);
            checkOutput($sformatf("clock_up@%0d", cyc), 32'(clock_up), 32'(tick_exp));
            checkOutput($sformatf("clock_div2@%0d", cyc), 32'(clock_div2), 32'(ph_exp));
            checkOutput($sformatf("in_ready@%0d", cyc), 32'(in_ready), 32'(tick_exp & ~ph_exp));
            checkOutput($sformatf("clock_in@%0d", cyc), 32'(clock_in), 32'(tick_exp & ~ph_exp));
            checkOutput($sformatf("out_valid@%0d", cyc), 32'(out_valid),
                        32'(tick_exp && (cyc >= valid_from)));
            checkOutput($sformatf("busy@%0d", cyc), 32'(busy), 32'd1);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        enable2   = 1'b0;
        in_valid2 = 1'b0;
        applyStimulus(1'b0, 1'b0);
        step();
        step();

        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_clock_in", 32'(clock_in), 32'd0);
        checkOutput("rst_clock_div2", 32'(clock_div2), 32'd1);
        checkOutput("rst_clock_up", 32'(clock_up), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        checkOutput("rst_unf_cnt", 32'(unf_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_clock_div2_b", 32'(clock_div2_2), 32'd1);

        rstn = 1'b1;
        step();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Priming with valid data: 8 loads, then outputs valid from the next tick.
        applyStimulus(1'b1, 1'b1);
        cyc = 0;
        runTo(68, 68);

        // Starve three load slots while running.
        applyStimulus(1'b1, 1'b0);
        runTo(73, 68);
        checkOutput("unf_first", 32'(underflow), 32'd1);
        checkOutput("unf_cnt_first", 32'(unf_cnt), 32'd1);
        runTo(89, 68);
        checkOutput("unf_three", 32'(underflow), 32'd1);
        checkOutput("unf_cnt_three", 32'(unf_cnt), 32'd3);
        checkOutput("unf_still_run", 32'(busy), 32'd1);

        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        step();
        cyc++;
        checkOutput("toggle_stop_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1);
        step();
        cyc++;
        checkOutput("toggle_unf_clr", 32'(underflow), 32'd0);
        checkOutput("toggle_cnt_clr", 32'(unf_cnt), 32'd0);
        checkOutput("toggle_busy", 32'(busy), 32'd1);

        // Graceful stop requested during an a0 tick.
        runTo(92, 68);
        applyStimulus(1'b0, 1'b0);
        step();
        checkOutput("stop_busy_93", 32'(busy), 32'd1);
        checkOutput("stop_up_93", 32'(clock_up), 32'd0);
        step();
        step();
        step();
        checkOutput("stop_a1_up", 32'(clock_up), 32'd1);
        checkOutput("stop_a1_div2", 32'(clock_div2), 32'd0);
        checkOutput("stop_a1_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stop_a1_clock_in", 32'(clock_in), 32'd0);
        checkOutput("stop_a1_busy", 32'(busy), 32'd1);
        step();
        checkOutput("stop_idle_busy", 32'(busy), 32'd0);
        checkOutput("stop_idle_div2", 32'(clock_div2), 32'd1);
        checkOutput("stop_idle_up", 32'(clock_up), 32'd0);
        checkOutput("stop_no_unf", 32'(underflow), 32'd0);
        checkOutput("stop_idle_in_ready", 32'(in_ready), 32'd0);

        // Abort in PRIME after three samples, while on the a1 half.
        applyStimulus(1'b1, 1'b1);
        cyc = 0;
        runTo(30, 1000);
        applyStimulus(1'b0, 1'b1);
        step();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_div2", 32'(clock_div2), 32'd1);
        checkOutput("abort_up", 32'(clock_up), 32'd0);

        // Restart must prime a full eight samples from a0.
        applyStimulus(1'b1, 1'b1);
        cyc = 0;
        runTo(68, 68);

        // Asynchronous reset between edges during an a1 load slot.
        applyStimulus(1'b1, 1'b0);
        runTo(80, 68);
        checkOutput("pre_rst_unf", 32'(underflow), 32'd1);
        checkOutput("pre_rst_unf_cnt", 32'(unf_cnt), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_clock_in", 32'(clock_in), 32'd0);
        checkOutput("arst_div2", 32'(clock_div2), 32'd1);
        checkOutput("arst_up", 32'(clock_up), 32'd0);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_unf", 32'(underflow), 32'd0);
        checkOutput("arst_unf_cnt", 32'(unf_cnt), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clock);
        rstn = 1'b1;
        step();

        // Fast-rate instance, permanently starved: 5 underflows saturate a 2-bit count.
        enable2   = 1'b1;
        in_valid2 = 1'b0;
        for (int f = 1; f <= 21; f++) begin
            step();
            checkOutput($sformatf("b_clock_up@%0d", f), 32'(clock_up2), 32'(f % 2 == 0));
            checkOutput($sformatf("b_in_ready@%0d", f), 32'(in_ready2), 32'(f % 4 == 0));
            if (f == 9)
                checkOutput("b_unf_cnt_two", 32'(unf_cnt2), 32'd2);
        end
        checkOutput("b_unf_sat", 32'(unf_cnt2), 32'd3);
        checkOutput("b_underflow", 32'(underflow2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
